// File: rtl/parametric_burst_sequencer_if.sv
// Bus between the instruction decoder and the burst sequencer: command handshake,
// register-file write port, tensor core result read port and compute strobes.
interface parametric_burst_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int MATRIX_DIM   = 3,
    parameter int NUM_MATRICES = 2,
    parameter int LANES        = 4,
    parameter int READ_LANES   = 2
);
    localparam int DIM2   = MATRIX_DIM * MATRIX_DIM;
    localparam int BASE_W = $clog2(NUM_MATRICES * DIM2) + 1;

    logic                             cmd_valid_in;
    logic [1:0]                       cmd_select_in;
    logic                             cmd_ready_out;

    logic [LANES*DATA_WIDTH-1:0]      write_data_in;
    logic                             write_enable_out;
    logic [LANES*DATA_WIDTH-1:0]      write_data_out;
    logic [BASE_W-1:0]                write_element_base_out;
    logic [LANES-1:0]                 write_lane_mask_out;

    logic [DIM2*DATA_WIDTH-1:0]       result_data_in;
    logic                             read_valid_out;
    logic [READ_LANES*DATA_WIDTH-1:0] read_data_out;
    logic [READ_LANES-1:0]            read_lane_mask_out;

    logic                             compute_start_out;
    logic                             result_commit_out;
    logic                             busy_out;

    // Decoder / tensor core side
    modport master (
        output cmd_valid_in, cmd_select_in, write_data_in, result_data_in,
        input  cmd_ready_out, write_enable_out, write_data_out, write_element_base_out,
               write_lane_mask_out, read_valid_out, read_data_out, read_lane_mask_out,
               compute_start_out, result_commit_out, busy_out
    );

    // Sequencer side
    modport slave (
        input  cmd_valid_in, cmd_select_in, write_data_in, result_data_in,
        output cmd_ready_out, write_enable_out, write_data_out, write_element_base_out,
               write_lane_mask_out, read_valid_out, read_data_out, read_lane_mask_out,
               compute_start_out, result_commit_out, busy_out
    );
endinterface

// File: rtl/parametric_burst_sequencer.sv
// Burst and compute sequencer for the tensor core: streams operand matrices into the
// register file, streams the result matrix out, and times compute with a fixed latency.
module parametric_burst_sequencer #(
    parameter int DATA_WIDTH      = 8,
    parameter int MATRIX_DIM      = 3,
    parameter int NUM_MATRICES    = 2,
    parameter int LANES           = 4,
    parameter int READ_LANES      = 2,
    parameter int COMPUTE_LATENCY = 5
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic                        soft_reset_in,
    parametric_burst_sequencer_if.slave bus
);
    localparam int DIM2        = MATRIX_DIM * MATRIX_DIM;
    localparam int WRITE_ELEMS = NUM_MATRICES * DIM2;
    localparam int WRITE_BEATS = (WRITE_ELEMS + LANES - 1) / LANES;
    localparam int READ_BEATS  = (DIM2 + READ_LANES - 1) / READ_LANES;
    localparam int BASE_W      = $clog2(WRITE_ELEMS) + 1;
    localparam int RBASE_W     = $clog2(DIM2) + 1;
    localparam int WBEAT_W     = $clog2(WRITE_BEATS + 1);
    localparam int RBEAT_W     = $clog2(READ_BEATS + 1);
    localparam int TIMER_W     = $clog2(COMPUTE_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BURST, COMPUTE} state_t;

    state_t                     state;
    logic [WBEAT_W-1:0]         write_beat;
    logic [RBEAT_W-1:0]         read_beat;
    logic [TIMER_W-1:0]         timer;

    logic                       cmd_ready;
    logic                       write_enable;
    logic [BASE_W-1:0]          write_base;
    logic [LANES-1:0]           write_mask;
    logic                       read_valid;
    logic [RBASE_W-1:0]         read_base;
    logic [READ_LANES-1:0]      read_mask;
    logic                       compute_start;
    logic                       result_commit;
    logic                       busy;

    logic                       accept;
    logic                       soft_clear;
    logic                       wants_write;
    logic                       wants_read;
    logic                       write_more;
    logic                       read_more;
    logic [LANES*DATA_WIDTH-1:0]      write_data;
    logic [READ_LANES*DATA_WIDTH-1:0] read_data;

    function automatic logic [LANES-1:0] write_mask_for(input int base);
        logic [LANES-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++) m[l] = (base + l) < WRITE_ELEMS;
        return m;
    endfunction

    function automatic logic [READ_LANES-1:0] read_mask_for(input int base);
        logic [READ_LANES-1:0] m;
        m = '0;
        for (int l = 0; l < READ_LANES; l++) m[l] = (base + l) < DIM2;
        return m;
    endfunction

    // The instruction bus carries write payload, so a decoded soft reset is only trusted
    // when no write beat is on the bus.
    assign accept      = bus.cmd_valid_in && cmd_ready;
    assign soft_clear  = soft_reset_in && !write_enable;
    assign wants_write = (bus.cmd_select_in == 2'b01) || (bus.cmd_select_in == 2'b10);
    assign wants_read  = (bus.cmd_select_in == 2'b00) || (bus.cmd_select_in == 2'b10);
    assign write_more  = write_enable && (write_beat != WBEAT_W'(WRITE_BEATS - 1));
    assign read_more   = read_valid && (read_beat != RBEAT_W'(READ_BEATS - 1));

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state         <= IDLE;
            write_beat    <= '0;
            read_beat     <= '0;
            timer         <= '0;
            cmd_ready     <= 1'b1;
            write_enable  <= 1'b0;
            write_base    <= '0;
            write_mask    <= '0;
            read_valid    <= 1'b0;
            read_base     <= '0;
            read_mask     <= '0;
            compute_start <= 1'b0;
            result_commit <= 1'b0;
            busy          <= 1'b0;
        end else if (soft_clear) begin
            state         <= IDLE;
            write_beat    <= '0;
            read_beat     <= '0;
            timer         <= '0;
            cmd_ready     <= 1'b1;
            write_enable  <= 1'b0;
            write_base    <= '0;
            write_mask    <= '0;
            read_valid    <= 1'b0;
            read_base     <= '0;
            read_mask     <= '0;
            compute_start <= 1'b0;
            result_commit <= 1'b0;
            busy          <= 1'b0;
        end else begin
            compute_start <= 1'b0;
            result_commit <= 1'b0;
            // Commands are only accepted in IDLE or the commit cycle, so both share this path.
            if (accept) begin
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
                if (bus.cmd_select_in == 2'b11) begin
                    state         <= COMPUTE;
                    compute_start <= 1'b1;
                    timer         <= TIMER_W'(1);
                end else begin
                    state <= BURST;
                    timer <= '0;
                    if (wants_write) begin
                        write_enable <= 1'b1;
                        write_beat   <= '0;
                        write_base   <= '0;
                        write_mask   <= write_mask_for(0);
                    end
                    if (wants_read) begin
                        read_valid <= 1'b1;
                        read_beat  <= '0;
                        read_base  <= '0;
                        read_mask  <= read_mask_for(0);
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        cmd_ready <= 1'b1;
                    end
                    BURST: begin
                        if (write_more) begin
                            write_beat <= write_beat + 1'b1;
                            write_base <= BASE_W'(int'(write_base) + LANES);
                            write_mask <= write_mask_for(int'(write_base) + LANES);
                        end else begin
                            write_enable <= 1'b0;
                            write_beat   <= '0;
                            write_base   <= '0;
                            write_mask   <= '0;
                        end
                        if (read_more) begin
                            read_beat <= read_beat + 1'b1;
                            read_base <= RBASE_W'(int'(read_base) + READ_LANES);
                            read_mask <= read_mask_for(int'(read_base) + READ_LANES);
                        end else begin
                            read_valid <= 1'b0;
                            read_beat  <= '0;
                            read_base  <= '0;
                            read_mask  <= '0;
                        end
                        if (!write_more && !read_more) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end
                    COMPUTE: begin
                        // timer holds the number of cycles since acceptance
                        if (result_commit) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                            if (timer == TIMER_W'(COMPUTE_LATENCY - 1)) begin
                                result_commit <= 1'b1;
                                cmd_ready     <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        write_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (write_mask[l]) write_data[l*DATA_WIDTH +: DATA_WIDTH] = bus.write_data_in[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Masked lanes never index past the result matrix, so only valid lanes are selected.
    always_comb begin
        read_data = '0;
        for (int l = 0; l < READ_LANES; l++) begin
            if (read_mask[l]) begin
                read_data[l*DATA_WIDTH +: DATA_WIDTH] =
                    bus.result_data_in[(int'(read_base) + l)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.cmd_ready_out          = cmd_ready;
    assign bus.write_enable_out       = write_enable;
    assign bus.write_data_out         = write_data;
    assign bus.write_element_base_out = write_base;
    assign bus.write_lane_mask_out    = write_mask;
    assign bus.read_valid_out         = read_valid;
    assign bus.read_data_out          = read_data;
    assign bus.read_lane_mask_out     = read_mask;
    assign bus.compute_start_out      = compute_start;
    assign bus.result_commit_out      = result_commit;
    assign bus.busy_out               = busy;
endmodule
